// File: rtl/io_responder.sv
// io_responder: memory-mapped I/O target for the core's external port with scratch, GPIO,
// a 64-bit timer, a down-counter interrupt source and an ID register.
module io_responder #(
  parameter int              A_SZ        = 32,
  parameter logic [A_SZ-1:0] IO_BASE     = 32'hFFFF_0000,
  parameter int              WAIT_STATES = 0,
  parameter logic [31:0]     ID_VALUE    = 32'h524B_3149
) (
  input  logic            clk_in,
  input  logic            reset_in,
  input  logic            io_req,
  input  logic [A_SZ-1:0] io_addr,
  input  logic            io_rd,
  input  logic            io_wr,
  input  logic [31:0]     io_wr_data,
  output logic            io_ack,
  output logic            io_ack_fault,
  output logic [31:0]     io_rd_data,
  input  logic [31:0]     gpio_in,
  output logic [31:0]     gpio_out,
  output logic            ext_irq
);
  localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2, TURN = 2'd3;
  localparam logic [3:0] WS = 4'(WAIT_STATES);
  logic [1:0] state;
  logic [3:0] wcnt, idx;
  logic [A_SZ-1:0] addr_q, off;
  logic rd_q, wr_q, fault, do_wr, do_rd, ctrl_wr, dcnt_ld, dcnt_hit, en, pend;
  logic [31:0] data_q, scratch0, scratch1, gpio_s1, gpio_s2, snap, dcnt, rdata;
  logic [63:0] timer;
  assign off = addr_q - IO_BASE;
  assign idx = off[5:2];
  assign fault = addr_q < IO_BASE || off >= A_SZ'(36) || addr_q[1:0] != 2'b00 || rd_q == wr_q
    || (wr_q && (idx == 4'd3 || idx == 4'd4 || idx == 4'd5 || idx == 4'd8));
  assign do_wr = state == RESP && !fault && wr_q;
  assign do_rd = state == RESP && !fault && rd_q;
  assign ctrl_wr = do_wr && idx == 4'd7;
  assign dcnt_ld = do_wr && idx == 4'd6;
  // a load landing on the 1->0 step suppresses the pend it would have raised
  assign dcnt_hit = !dcnt_ld && dcnt == 32'd1;
  always_comb begin
    rdata = '0;
    case (idx)
      4'd0: rdata = scratch0;
      4'd1: rdata = scratch1;
      4'd2: rdata = gpio_out;
      4'd3: rdata = gpio_s2;
      4'd4: rdata = timer[31:0];
      4'd5: rdata = snap;
      4'd6: rdata = dcnt;
      4'd7: rdata = {30'd0, pend, en};
      4'd8: rdata = ID_VALUE;
      default: rdata = '0;
    endcase
  end
  always_ff @(posedge clk_in or negedge reset_in)
    if (!reset_in) begin
      state <= IDLE;
      wcnt <= '0;
      addr_q <= '0;
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      data_q <= '0;
      io_ack <= 1'b0;
      io_ack_fault <= 1'b0;
      io_rd_data <= '0;
    end else begin
      io_ack <= 1'b0;
      io_ack_fault <= 1'b0;
      io_rd_data <= '0;
      case (state)
        IDLE: if (io_req) begin
          addr_q <= io_addr;
          rd_q <= io_rd;
          wr_q <= io_wr;
          data_q <= io_wr_data;
          wcnt <= WS;
          state <= WS == 4'd0 ? RESP : WAIT;
        end
        WAIT: begin
          wcnt <= wcnt - 4'd1;
          state <= wcnt == 4'd1 ? RESP : WAIT;
        end
        RESP: begin
          io_ack <= !fault;
          io_ack_fault <= fault;
          io_rd_data <= do_rd ? rdata : '0;
          state <= TURN;
        end
        default: state <= IDLE;
      endcase
    end
  always_ff @(posedge clk_in or negedge reset_in)
    if (!reset_in) begin
      scratch0 <= '0;
      scratch1 <= '0;
      gpio_out <= '0;
      gpio_s1 <= '0;
      gpio_s2 <= '0;
      timer <= '0;
      snap <= '0;
      dcnt <= '0;
      en <= 1'b0;
      pend <= 1'b0;
      ext_irq <= 1'b0;
    end else begin
      timer <= timer + 64'd1;
      gpio_s1 <= gpio_in;
      gpio_s2 <= gpio_s1;
      if (do_wr && idx == 4'd0) scratch0 <= data_q;
      if (do_wr && idx == 4'd1) scratch1 <= data_q;
      if (do_wr && idx == 4'd2) gpio_out <= data_q;
      // low-half read freezes the high half so a following TIMER_HI read is coherent
      if (do_rd && idx == 4'd4) snap <= timer[63:32];
      dcnt <= dcnt_ld ? data_q : dcnt != 32'd0 ? dcnt - 32'd1 : dcnt;
      en <= ctrl_wr ? data_q[0] : en;
      pend <= dcnt_hit | (pend & ~(ctrl_wr & data_q[1]));
      ext_irq <= en & pend;
    end
endmodule
